// File: rtl/iter_shift_unit.sv
// Multi-cycle shift unit: shifts a latched operand one bit per cycle for SLL/SRL/SRA
// and their variable forms, signalling completion with a one-cycle done pulse.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shamt_src,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] work;
  logic [1:0]       op_q;
  logic [SHW-1:0]   n_in;
  logic [WIDTH-1:0] work_nxt;
  logic             unused_shamt_hi;

  // One-bit shift step; the reserved encoding falls through to SLL.
  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                  input logic [1:0]       o);
    logic signed [WIDTH-1:0] s;
    s = signed'(v);
    case (o)
      OP_SRL:  return v >> 1;
      OP_SRA:  return unsigned'(s >>> 1);
      default: return v << 1;
    endcase
  endfunction

  assign n_in            = shamt_src[SHW-1:0];
  assign unused_shamt_hi = ^shamt_src[WIDTH-1:SHW];
  assign work_nxt        = shift_step(work, op_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      work   <= '0;
      op_q   <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else if (flush) begin
      // A flush in DONE leaves this cycle's pulse intact; it only blocks a new accept.
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work <= operand;
            op_q <= op;
            cnt  <= n_in;
            if (n_in == '0) begin
              result <= operand;
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - 1'b1;
          if (cnt == SHW'(1)) begin
            result <= work_nxt;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed self-checking bench for iter_shift_unit.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [1:0]  op;
  logic [31:0] operand, shamt_src;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int fails = 0;
  int lat, bcnt, cnt_ev;

  iter_shift_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .operand(operand), .shamt_src(shamt_src),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start for one accepting edge, then wait (bounded) for done.
  // lat = edges from accept to the done cycle, bcnt = busy cycles seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                        output int l, output int b);
    op = o; operand = a; shamt_src = s; start = 1'b1;
    tick();
    start = 1'b0;
    l = 1; b = 0;
    while (!done && l < 40) begin
      if (busy) b++;
      tick();
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
    operand = '0; shamt_src = '0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 32'h0);

    // SLL by 31
    run_op(2'b00, 32'h0000_0001, 32'h0000_001F, lat, bcnt);
    check("sll31_lat", lat, 32);
    check("sll31_busy_cycles", bcnt, 31);
    check("sll31_result", result, 32'h8000_0000);
    check("sll31_busy_at_done", busy, 0);
    tick();
    check("sll31_done_pulse", done, 0);

    // SRA vs SRL
    run_op(2'b10, 32'h8000_0000, 32'h0000_0004, lat, bcnt);
    check("sra4_lat", lat, 5);
    check("sra4_result", result, 32'hF800_0000);
    tick();
    run_op(2'b01, 32'h8000_0000, 32'h0000_0004, lat, bcnt);
    check("srl4_lat", lat, 5);
    check("srl4_result", result, 32'h0800_0000);
    tick();

    // SRA of a positive value fills with zero
    run_op(2'b10, 32'h4000_0000, 32'h0000_0003, lat, bcnt);
    check("sra_pos_result", result, 32'h0800_0000);
    tick();

    // Reserved op acts as SLL
    run_op(2'b11, 32'h0000_0003, 32'h0000_0002, lat, bcnt);
    check("rsvd_lat", lat, 3);
    check("rsvd_result", result, 32'h0000_000C);
    tick();

    // Upper shamt bits ignored -> n = 0
    run_op(2'b01, 32'h1234_5678, 32'hFFFF_FFE0, lat, bcnt);
    check("n0_lat", lat, 1);
    check("n0_busy_cycles", bcnt, 0);
    check("n0_result", result, 32'h1234_5678);
    tick();
    check("n0_done_pulse", done, 0);

    // start during SHIFT is ignored
    op = 2'b00; operand = 32'h0000_0005; shamt_src = 32'd10; start = 1'b1;
    tick();                       // cycle T+1
    start = 1'b0;
    tick(); tick();               // cycle T+3
    op = 2'b01; operand = 32'hFFFF_FFFF; shamt_src = 32'd3; start = 1'b1;
    tick();                       // cycle T+4
    start = 1'b0;
    lat = 4;
    while (!done && lat < 40) begin tick(); lat++; end
    check("ign_lat", lat, 11);
    check("ign_result", result, 32'h0000_1400);
    cnt_ev = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done || busy) cnt_ev++; end
    check("ign_no_second_op", cnt_ev, 0);

    // flush mid-operation
    op = 2'b00; operand = 32'h0000_0007; shamt_src = 32'd10; start = 1'b1;
    tick();                       // cycle T+1
    start = 1'b0;
    tick(); tick(); tick(); tick(); // cycle T+5
    flush = 1'b1;
    tick();                       // cycle T+6
    flush = 1'b0;
    check("flush_busy", busy, 0);
    check("flush_done", done, 0);
    check("flush_result", result, 32'h0000_1400);
    run_op(2'b00, 32'h0000_0001, 32'd2, lat, bcnt);
    check("post_flush_lat", lat, 3);
    check("post_flush_result", result, 32'h0000_0004);
    tick();

    // flush in the DONE cycle keeps the pulse but blocks a new start
    op = 2'b00; operand = 32'h0000_0009; shamt_src = 32'd0; start = 1'b1;
    tick();
    check("flushdone_done", done, 1);
    check("flushdone_result", result, 32'h0000_0009);
    flush = 1'b1; shamt_src = 32'd2;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flushdone_blocked_busy", busy, 0);
    check("flushdone_blocked_done", done, 0);
    tick();

    // reset mid-operation
    op = 2'b00; operand = 32'h0000_0001; shamt_src = 32'd8; start = 1'b1;
    tick();                       // cycle T+1
    start = 1'b0;
    tick();                       // cycle T+2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 32'h0);
    cnt_ev = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (done || busy) cnt_ev++; end
    check("rst_no_done", cnt_ev, 0);

    // back-to-back n = 1 with start held high
    op = 2'b00; operand = 32'h0000_0001; shamt_src = 32'd1; start = 1'b1;
    tick();                       // cycle T+1
    check("b2b_busy1", busy, 1);
    check("b2b_done1_early", done, 0);
    operand = 32'h0000_0003;
    tick();                       // cycle T+2
    check("b2b_done1", done, 1);
    check("b2b_result1", result, 32'h0000_0002);
    tick();                       // cycle T+3
    check("b2b_busy2", busy, 1);
    check("b2b_done2_early", done, 0);
    tick();                       // cycle T+4
    start = 1'b0;
    check("b2b_done2", done, 1);
    check("b2b_result2", result, 32'h0000_0006);
    tick();
    check("b2b_idle_busy", busy, 0);
    check("b2b_idle_done", done, 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/iter_shift_unit.md
# iter_shift_unit

Multi-cycle shift execution unit for the MIPS EX stage. It consumes the 32-bit output of the operand-select stage, of which only bits [4:0] serve as the shift amount. It shifts a latched operand one bit position per cycle and reports completion with a single-cycle `done` pulse. It implements SLL/SRL/SRA and their variable forms (SLLV/SRLV/SRAV), so the combinational ALU carries no barrel shifter.

## Interface
Parameters:
- `WIDTH`, 32: datapath width. Only 32 is supported.
- `SHW`, 5: shift-amount width, log2(`WIDTH`).

Ports:
- `clk`  in  1  system clock; the only clock; all state updates on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a shift. Accepted only when the unit is not busy (state IDLE or DONE).
- `flush`  in  1  synchronous pipeline kill. Aborts any operation in flight.
- `op`  in  2  shift operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved (executes as SLL).
- `operand`  in  32  value to shift (rt).
- `shamt_src`  in  32  operand-select output. Only bits [4:0] are used; bits [31:5] are ignored.
- `busy`  out  1  high while state is SHIFT.
- `done`  out  1  one-cycle pulse when `result` holds a new value.
- `result`  out  32  shifted value. Holds its value until the next completion.

## Operation
- State machine with three states: IDLE, SHIFT, DONE.
- IDLE:
  - On `start`, latch `operand` into the work register, latch `op`, and load the counter with `shamt_src[4:0]` (value n).
  - If n = 0, go to DONE. Otherwise go to SHIFT.
- SHIFT, each cycle:
  - Shift the work register one bit and decrement the counter.
  - SLL: shift left, fill 0. SRL: shift right, fill 0. SRA: shift right, fill with bit 31 of the work register.
  - When the counter goes from 1 to 0, load `result` from the shifted value and go to DONE.
- DONE:
  - `done` is high for this cycle only.
  - If `start` is also high in this cycle, accept the new request as IDLE does (back-to-back operation). Otherwise go to IDLE.
- For n = 0: `result` is loaded with `operand` on the transition from IDLE to DONE.
- `start` while in SHIFT is ignored; no queueing.
- `flush`:
  - Forces IDLE on the next edge. No `done` is produced and `result` is unchanged.
  - Takes priority over `start` in the same cycle.
  - A flush in the DONE cycle does not cancel that cycle's `done` pulse; it only blocks a simultaneous `start`.
- `rst` takes priority over everything else.
  - Outputs after reset: state IDLE, `busy` = 0, `done` = 0, `result` = 0x00000000; counter and work register cleared.
  - Reset during SHIFT abandons the operation and produces no `done`.
- The counter is 5 bits wide and never wraps: it is loaded only on accept and decremented only in SHIFT.

## Timing
- Start accepted at edge T with shift amount n:
  - n > 0: SHIFT occupies cycles T+1 through T+n, and `done` is high in cycle T+n+1.
  - n = 0: `done` is high in cycle T+1.
  - Latency is therefore n+1 cycles; n = 31 gives 32 cycles.
- `busy` is high exactly during the SHIFT cycles. It is never high in the same cycle as `done`.
- `result` changes only on the edge that enters DONE, and is stable whenever `done` = 1.
- With `start` held high continuously, one operation is accepted per n+1 cycles and there are no idle gaps.
- Inputs `operand`, `op` and `shamt_src` are sampled only on the accepting edge. Changes to them during SHIFT have no effect.

## Test plan
- Reset, then idle for 3 cycles -> `busy` = 0, `done` = 0, `result` = 0x00000000.
- SLL: `operand` = 0x00000001, `shamt_src` = 0x0000001F -> `busy` high for 31 cycles, `done` at T+32, `result` = 0x80000000.
- SRA vs SRL: `operand` = 0x80000000, n = 4 -> SRA gives 0xF8000000 and SRL gives 0x08000000, each with `done` at T+5.
- Upper bits ignored: `shamt_src` = 0xFFFFFFE0, `operand` = 0x12345678 -> `done` at T+1, `result` = 0x12345678, `busy` never asserted.
- Mid-operation events:
  - SLL n = 10, then `start` with new operands at T+3 -> the second start is ignored and `result` equals the first operation's value at T+11.
  - Same operation with `flush` at T+5 -> no `done`, `result` unchanged, and a new start is accepted at T+6.
- Reset and back-to-back:
  - `rst` at T+2 during an n = 8 operation -> no `done`, all outputs at reset values.
  - Two back-to-back n = 1 operations with `start` held high -> `done` pulses at T+2 and T+4.
